// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and sizing helpers for the bit-serial add/subtract controller.
package serial_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int MIN_WIDTH = 2;

  // The bit counter needs at least one bit even for the narrowest datapath.
  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, reused serially by serial_add_ctrl.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit add/subtract: one full_adder cell, LSB-first, one bit per clock.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  generate
    if (WIDTH < MIN_WIDTH) begin : g_width_check
      $error("serial_add_ctrl: WIDTH must be at least 2");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Handshake readiness depends on the state register alone.
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            a_sh  <= in_a;
            b_sh  <= in_sub ? ~in_b : in_b;
            carry <= in_sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          out_sum <= {fa_sum, out_sum[WIDTH-1:1]};
          a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
          carry   <= fa_cout;
          cnt     <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            // carry currently holds the carry into the MSB.
            out_cout  <= fa_cout;
            out_ovf   <= carry ^ fa_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   prev_acc = -1;
  bit   spacing_chk = 0;
  logic prev_ov = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: plain wide arithmetic, flags from operand/result sign bits.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t    e;
    logic [W:0] s;
    if (sub) begin
      s     = {1'b0, a} + {1'b0, ~b} + 1;
      e.ovf = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      s     = {1'b0, a} + {1'b0, b};
      e.ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end
    e.sum  = s[W-1:0];
    e.cout = s[W];
    e.acc  = 0;
    return e;
  endfunction

  // Drive one operand set; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t e;
    bit   done = 0;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e     = model(a, b, sub);
        e.acc = cyc + 1;
        sb.push_back(e);
        if (spacing_chk && prev_acc >= 0) check("accept_spacing", e.acc - prev_acc, 10);
        prev_acc = e.acc;
        done     = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    $display("op a=0x%02h b=0x%02h sub=%0d accepted=%0d", a, b, sub, done);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  // Monitor: latency on out_valid rise, result compare on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) check("spurious_valid", out_valid, 0);
        else check("latency", cyc - sb[0].acc, W);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_result", out_valid, 0);
        end else begin
          e = sb.pop_front();
          check("sum", out_sum, e.sum);
          check("cout", out_cout, e.cout);
          check("ovf", out_ovf, e.ovf);
          $display("result sum=0x%02h cout=%0d ovf=%0d exp=0x%02h/%0d/%0d",
                   out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
        end
      end
    end
    prev_ov = out_valid;
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_cout", out_cout, 0);
    check("rst_ovf", out_ovf, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(8'h5A, 8'h33, 1'b0);
    send(8'hFF, 8'h01, 1'b0);
    send(8'h80, 8'h80, 1'b0);
    send(8'h10, 8'h20, 1'b1);
    send(8'h80, 8'h01, 1'b1);
    send(8'h37, 8'h00, 1'b1);
    drain();

    // Backpressure: result must hold while out_ready stays low.
    out_ready = 1'b0;
    send(8'hA5, 8'h3C, 1'b0);
    for (int i = 0; i < 50 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_sum", out_sum, 8'hE1);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_taken", out_valid, 0);
    drain();

    // Reset in the middle of RUN discards the operation.
    send(8'hC3, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h01, 8'h02, 1'b0);
    drain();

    // Back-to-back operations with in_valid kept high.
    spacing_chk = 1;
    prev_acc    = -1;
    send(8'h12, 8'h34, 1'b0);
    send(8'h7F, 8'h01, 1'b0);
    send(8'h00, 8'h01, 1'b1);
    send(8'hFE, 8'hFF, 1'b1);
    spacing_chk = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract controller that reuses the single 1-bit `full_adder` cell to compute WIDTH-bit sums. Operands are accepted over a valid/ready handshake and fed through the cell LSB-first, one bit per clock, with the carry held in a register. The result is presented over a second valid/ready handshake. It sits between an operand producer and a result consumer wherever area matters more than throughput.

## Interface
- WIDTH, 8: operand and result width in bits; minimum 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- in_valid  in  1  operand set valid.
- in_ready  out  1  controller can accept operands.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result bits.
- out_cout  out  1  carry out of MSB. For subtract it is 1 when there is no borrow.
- out_ovf  out  1  signed overflow (two's complement).
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- Reset values (async, while rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0.
  - out_sum=0, out_cout=0, out_ovf=0, busy=0.
  - bit counter=0, carry register=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch A; latch B, or ~B when in_sub=1; carry←in_sub; counter←0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, the cell gets A[0], B'[0] and carry.
  - Sum bit shifts into the result register MSB-first position, so after WIDTH shifts bit i sits at out_sum[i].
  - A and B' shift right; carry←Cout; counter increments.
  - On the cycle with counter=WIDTH−1, the carry-in to the MSB is captured for overflow.
  - out_ovf = carry_into_MSB ^ final Cout; out_cout = final Cout.
  - Then go to DONE.
- DONE:
  - out_valid=1. out_sum, out_cout and out_ovf are stable and held.
  - On out_valid&out_ready go to IDLE and clear out_valid.
  - Result registers keep their last value until the next operation overwrites them.
- Width rules:
  - Result is modulo 2^WIDTH.
  - Operands are unsigned for cout and two's complement for ovf. Both flags are always computed.
- Boundaries:
  - in_valid while busy: ignored. The producer must hold it until in_ready.
  - The DONE→IDLE handshake and a new in_valid in the same cycle do not overlap. The new operand is accepted in IDLE on the following edge.
  - rst_n asserted mid-RUN or mid-DONE: the operation is discarded immediately, with reset values as above. No partial result is ever signalled.
  - in_sub with B=0: A−0 = A with cout=1.

## Timing
- Operand handshake at edge k.
- RUN occupies edges k+1 … k+WIDTH; out_valid rises after edge k+WIDTH.
- Latency is WIDTH cycles from accept to out_valid.
- With out_ready held high, in_ready returns after edge k+WIDTH+1.
- Peak rate: one operation per WIDTH+2 cycles (10 for WIDTH=8).
- All outputs are registered except in_ready and busy, which decode from the state register only, with no input-to-output combinational path.

## Structure
- Package serial_add_pkg:
  - state enum {IDLE, RUN, DONE};
  - counter width constant `$clog2(WIDTH)` (minimum 1);
  - the WIDTH≥2 check.
- One sub-module: the existing `full_adder`, instantiated exactly once (A, B, Cin → Sum, Cout). All shifting, counting and flag logic lives in serial_add_ctrl.

## Test plan
- WIDTH=8, add 0x5A+0x33 → out_sum=0x8D, cout=0, ovf=1, out_valid exactly 8 cycles after accept.
- Add 0xFF+0x01 → out_sum=0x00, cout=1, ovf=0. Add 0x80+0x80 → 0x00, cout=1, ovf=1.
- Sub 0x10−0x20 → out_sum=0xF0, cout=0 (borrow), ovf=0. Sub 0x80−0x01 → 0x7F, cout=1, ovf=1.
- Backpressure: out_ready low 5 cycles in DONE → out_valid and result held constant, in_ready=0 throughout; the result is taken on the cycle out_ready rises.
- Reset asserted during RUN bit 3 → out_valid=0 and in_ready=1 immediately. The next operation 0x01+0x02 returns 0x03, unaffected.
- in_valid held high with out_ready=1 and 4 queued operations → accepts spaced exactly 10 cycles apart; all results correct, none dropped or duplicated.
